// File: rtl/exc_pkg.sv
// Shared types and constants for the exception controller: FSM state encoding,
// EStatus cause codes and the default handler entry address.
package exc_pkg;

   typedef enum logic [2:0] {
      NORMAL,
      TAKE,
      HANDLER,
      RETURN,
      FAULT
   } state_t;

   localparam logic [3:0] ESTAT_NONE  = 4'b0000;
   localparam logic [3:0] ESTAT_IRQ   = 4'b0001;
   localparam logic [3:0] ESTAT_INVOP = 4'b0010;

   localparam logic [63:0] EXC_VECTOR_DEFAULT = 64'h0000_0000_0000_00D8;

endpackage

// File: rtl/irq_sync.sv
// External interrupt front end: synchroniser, rising-edge detector and
// pending latch with set-over-clear priority.
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic irq_in,
   input  logic ack,
   output logic irq_pending
);

   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   sync_q;
   logic                   sync_qq;
   logic                   rise;
   logic                   pending_d;

   // Detector compares two flops behind the synchroniser, giving the
   // SYNC_STAGES+2 edge latency from irq_in to irq_pending.
   assign rise = sync_q & ~sync_qq;

   always_comb begin
      pending_d = irq_pending;
      if (ack) begin
         pending_d = 1'b0;
      end
      if (rise) begin
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_chain  <= '0;
         sync_q      <= 1'b0;
         sync_qq     <= 1'b0;
         irq_pending <= 1'b0;
      end else begin
         sync_chain  <= {sync_chain[SYNC_STAGES-2:0], irq_in};
         sync_q      <= sync_chain[SYNC_STAGES-1];
         sync_qq     <= sync_q;
         irq_pending <= pending_d;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: turns decoder Exc/ERet into PC redirects and flushes,
// holds ELR/ESR, and gates the external interrupt while a handler runs.
module exc_ctrl
   import exc_pkg::*;
#(
   parameter int unsigned   DW          = 64,
   parameter logic [DW-1:0] EXC_VECTOR  = DW'(EXC_VECTOR_DEFAULT),
   parameter int unsigned   SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          irq_in,
   output logic          ExtIRQ,
   output logic          ExtIAck,
   input  logic          Exc,
   input  logic [3:0]    EStatus,
   input  logic          ERet,
   input  logic [DW-1:0] PC_E,
   input  logic          sysreg_sel,
   output logic [DW-1:0] sysreg_rdata,
   output logic          redirect,
   output logic [DW-1:0] redirect_pc,
   output logic          flush,
   output logic          in_handler,
   output logic          halted
);

   state_t          state_q, state_d;
   logic [DW-1:0]   elr_q;
   logic [DW-1:0]   esr_q;
   logic            save_exc;
   logic            irq_pending;

   // Ack only from NORMAL, so an IRQ cause seen inside a handler never clears pending.
   assign ExtIAck = (state_q == NORMAL) & Exc & (EStatus == ESTAT_IRQ);

   irq_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_irq_sync (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .ack        (ExtIAck),
      .irq_pending(irq_pending)
   );

   always_comb begin
      state_d  = state_q;
      save_exc = 1'b0;
      unique case (state_q)
         NORMAL: begin
            if (Exc) begin
               state_d  = TAKE;
               save_exc = 1'b1;
            end
         end
         TAKE:    state_d = HANDLER;
         HANDLER: begin
            if (Exc && (EStatus == ESTAT_INVOP)) begin
               state_d = FAULT;
            end else if (ERet) begin
               state_d = RETURN;
            end
         end
         RETURN:  state_d = NORMAL;
         FAULT:   state_d = FAULT;
         default: state_d = NORMAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= NORMAL;
         elr_q   <= '0;
         esr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (save_exc) begin
            elr_q <= PC_E;
            esr_q <= {{(DW-4){1'b0}}, EStatus};
         end
      end
   end

   always_comb begin
      redirect    = 1'b0;
      redirect_pc = '0;
      in_handler  = 1'b0;
      halted      = 1'b0;
      unique case (state_q)
         TAKE: begin
            redirect    = 1'b1;
            redirect_pc = EXC_VECTOR;
         end
         HANDLER: in_handler = 1'b1;
         RETURN: begin
            redirect    = 1'b1;
            redirect_pc = elr_q;
         end
         FAULT: begin
            redirect    = 1'b1;
            redirect_pc = EXC_VECTOR;
            halted      = 1'b1;
         end
         default: ;
      endcase
   end

   assign flush        = redirect;
   assign ExtIRQ       = irq_pending & (state_q == NORMAL);
   assign sysreg_rdata = sysreg_sel ? esr_q : elr_q;

endmodule
